// File: rtl/alarm_pkg.sv
// alarm_pkg
// Types and constants shared by the alarm blocks (state controller, clock
// counter, ringer).
//   alarm_state_t : ringer event state (IDLE / RINGING / SNOOZE)
//   TIME_W        : width of hour/minute/second fields
//   MAX_HOUR/MAX_MIN/MAX_SEC : largest legal value of each time field
package alarm_pkg;

    localparam int TIME_W   = 6;
    localparam int MAX_HOUR = 23;
    localparam int MAX_MIN  = 59;
    localparam int MAX_SEC  = 59;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } alarm_state_t;

endpackage

// File: rtl/tick_timer.sv
// tick_timer
// Loadable down-counter advanced by a once-per-second strobe.
//   clk, rst : clock, synchronous active-high reset
//   load     : load `value` into the counter (wins over tick)
//   value    : reload value
//   tick     : decrement strobe; the counter saturates at 0
//   zero     : counter is 0, or this tick takes it from 1 to 0
module tick_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         tick,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= value;
        end else if (tick && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    // Flag expiry on the tick that consumes the last count, so the owner
    // can leave its state on exactly the Nth tick after loading.
    assign zero = (cnt == '0) || (tick && (cnt == W'(1)));

endmodule

// File: rtl/alarm_ringer.sv
// alarm_ringer
// Compares the running time against the stored alarm time once per second,
// rings the buzzer, and handles snooze (bounded count) and stop requests.
//   clk, rst                    : clock, synchronous active-high reset
//   tick_1hz                    : one-cycle strobe per second
//   cur_hour/cur_min/cur_sec    : current time
//   sethour/setmin              : stored alarm time
//   alarm_en                    : alarm armed; low forces IDLE
//   snooze, stop                : single-cycle request pulses
//   ring, buzzer, snoozing      : registered status / buzzer drive
//   snooze_cnt                  : snoozes used in the current event
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | no alarm event; waiting for a time match
// RINGING | buzzer active, ring timer counting down to auto-stop
// SNOOZE  | buzzer silent, snooze timer counting down to re-ring
module alarm_ringer
    import alarm_pkg::*;
#(
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int MAX_SNOOZE     = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick_1hz,
    input  logic [TIME_W-1:0] cur_hour,
    input  logic [TIME_W-1:0] cur_min,
    input  logic [TIME_W-1:0] cur_sec,
    input  logic [TIME_W-1:0] sethour,
    input  logic [TIME_W-1:0] setmin,
    input  logic              alarm_en,
    input  logic              snooze,
    input  logic              stop,
    output logic              ring,
    output logic              buzzer,
    output logic              snoozing,
    output logic [2:0]        snooze_cnt
);

    localparam int SNZ_TICKS = SNOOZE_MIN * 60;
    localparam int SNZ_W     = $clog2(SNZ_TICKS + 1);
    localparam int RING_W    = 8;

    alarm_state_t state, state_nxt;
    logic         buzzer_nxt;
    logic [2:0]   snooze_cnt_nxt;
    logic         match;
    logic         ring_load, ring_tick, ring_zero;
    logic         snz_load, snz_tick, snz_zero;

    assign match = alarm_en && tick_1hz
                && (cur_hour == sethour) && (cur_min == setmin)
                && (cur_sec == '0);

    // Timers see every tick of their own state; on cycles where a
    // higher-priority request wins, the timer's contents no longer matter
    // because it is reloaded before it is used again.
    assign ring_tick = tick_1hz && (state == ST_RINGING);
    assign snz_tick  = tick_1hz && (state == ST_SNOOZE);

    tick_timer #(.W(RING_W)) u_ring_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (ring_load),
        .value (RING_W'(RING_TIMEOUT_S)),
        .tick  (ring_tick),
        .zero  (ring_zero)
    );

    tick_timer #(.W(SNZ_W)) u_snooze_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (snz_load),
        .value (SNZ_W'(SNZ_TICKS)),
        .tick  (snz_tick),
        .zero  (snz_zero)
    );

    always_comb begin
        state_nxt      = state;
        buzzer_nxt     = buzzer;
        snooze_cnt_nxt = snooze_cnt;
        ring_load      = 1'b0;
        snz_load       = 1'b0;

        case (state)
            ST_IDLE: begin
                if (match) begin
                    state_nxt      = ST_RINGING;
                    buzzer_nxt     = 1'b1;
                    snooze_cnt_nxt = '0;
                    ring_load      = 1'b1;
                end
            end

            ST_RINGING: begin
                if (!alarm_en || stop) begin
                    state_nxt      = ST_IDLE;
                    buzzer_nxt     = 1'b0;
                    snooze_cnt_nxt = '0;
                end else if (snooze && (snooze_cnt < 3'(MAX_SNOOZE))) begin
                    state_nxt      = ST_SNOOZE;
                    buzzer_nxt     = 1'b0;
                    snooze_cnt_nxt = snooze_cnt + 3'd1;
                    snz_load       = 1'b1;
                end else if (tick_1hz) begin
                    if (ring_zero) begin
                        state_nxt  = ST_IDLE;
                        buzzer_nxt = 1'b0;
                    end else begin
                        buzzer_nxt = !buzzer;
                    end
                end
            end

            ST_SNOOZE: begin
                if (!alarm_en || stop) begin
                    state_nxt      = ST_IDLE;
                    buzzer_nxt     = 1'b0;
                    snooze_cnt_nxt = '0;
                end else if (tick_1hz && snz_zero) begin
                    state_nxt  = ST_RINGING;
                    buzzer_nxt = 1'b1;
                    ring_load  = 1'b1;
                end
            end

            default: begin
                state_nxt      = ST_IDLE;
                buzzer_nxt     = 1'b0;
                snooze_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            buzzer     <= 1'b0;
            snooze_cnt <= '0;
            ring       <= 1'b0;
            snoozing   <= 1'b0;
        end else begin
            state      <= state_nxt;
            buzzer     <= buzzer_nxt;
            snooze_cnt <= snooze_cnt_nxt;
            ring       <= (state_nxt == ST_RINGING);
            snoozing   <= (state_nxt == ST_SNOOZE);
        end
    end

endmodule

// File: tb/tb_alarm_ringer.sv
module tb_alarm_ringer;

    logic       clk = 1'b0;
    logic       rst;
    logic       tick_1hz;
    logic [5:0] cur_hour, cur_min, cur_sec;
    logic [5:0] sethour, setmin;
    logic       alarm_en, snooze, stop;
    logic       ring, buzzer, snoozing;
    logic [2:0] snooze_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alarm_ringer #(
        .SNOOZE_MIN     (5),
        .RING_TIMEOUT_S (60),
        .MAX_SNOOZE     (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick_1hz   (tick_1hz),
        .cur_hour   (cur_hour),
        .cur_min    (cur_min),
        .cur_sec    (cur_sec),
        .sethour    (sethour),
        .setmin     (setmin),
        .alarm_en   (alarm_en),
        .snooze     (snooze),
        .stop       (stop),
        .ring       (ring),
        .buzzer     (buzzer),
        .snoozing   (snoozing),
        .snooze_cnt (snooze_cnt)
    );

    // expected outputs packed as {ring, buzzer, snoozing, snooze_cnt[2:0]}
    typedef struct {
        logic       tick;
        logic [5:0] h;
        logic [5:0] m;
        logic [5:0] s;
        logic       en;
        logic       snz;
        logic       stp;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[20];

    function automatic logic [5:0] outs();
        return {ring, buzzer, snoozing, snooze_cnt};
    endfunction

    task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got r/b/s/cnt=%b required %b at %0t", name, got, exp, $time);
        end
    endtask

    task automatic set_time(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_hour = h;
        cur_min  = m;
        cur_sec  = s;
    endtask

    // apply one clock cycle of pulses, then sample 1 ns after the edge
    task automatic step(input logic t, input logic snz, input logic stp);
        tick_1hz = t;
        snooze   = snz;
        stop     = stp;
        @(posedge clk);
        #1;
        tick_1hz = 1'b0;
        snooze   = 1'b0;
        stop     = 1'b0;
    endtask

    // one tick followed by a quiet cycle, away from any match time
    task automatic quiet_tick();
        set_time(6'd12, 6'd0, 6'd1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic fire_alarm();
        set_time(6'd7, 6'd30, 6'd0);
        step(1'b1, 1'b0, 1'b0);
        set_time(6'd12, 6'd0, 6'd1);
    endtask

    initial begin
        rst      = 1'b1;
        tick_1hz = 1'b0;
        snooze   = 1'b0;
        stop     = 1'b0;
        alarm_en = 1'b1;
        sethour  = 6'd7;
        setmin   = 6'd30;
        set_time(6'd0, 6'd0, 6'd0);

        //              tick  h      m       s      en    snz   stp   exp r b s cnt
        tbl[0]  = '{1'b1, 6'd7, 6'd29, 6'd59, 1'b1, 1'b0, 1'b0, 6'b000000};
        tbl[1]  = '{1'b0, 6'd7, 6'd30, 6'd0,  1'b1, 1'b0, 1'b0, 6'b000000};
        tbl[2]  = '{1'b1, 6'd7, 6'd30, 6'd0,  1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[3]  = '{1'b1, 6'd7, 6'd30, 6'd1,  1'b1, 1'b0, 1'b0, 6'b000000};
        tbl[4]  = '{1'b1, 6'd7, 6'd31, 6'd0,  1'b1, 1'b0, 1'b0, 6'b000000};
        tbl[5]  = '{1'b1, 6'd7, 6'd30, 6'd0,  1'b1, 1'b0, 1'b0, 6'b110000};
        tbl[6]  = '{1'b1, 6'd7, 6'd30, 6'd1,  1'b1, 1'b0, 1'b0, 6'b100000};
        tbl[7]  = '{1'b0, 6'd7, 6'd30, 6'd1,  1'b1, 1'b0, 1'b0, 6'b100000};
        tbl[8]  = '{1'b1, 6'd7, 6'd30, 6'd2,  1'b1, 1'b0, 1'b0, 6'b110000};
        tbl[9]  = '{1'b1, 6'd7, 6'd30, 6'd0,  1'b1, 1'b0, 1'b0, 6'b100000};
        tbl[10] = '{1'b0, 6'd7, 6'd30, 6'd3,  1'b1, 1'b1, 1'b1, 6'b000000};
        tbl[11] = '{1'b1, 6'd7, 6'd30, 6'd0,  1'b1, 1'b0, 1'b0, 6'b110000};
        tbl[12] = '{1'b0, 6'd7, 6'd30, 6'd1,  1'b1, 1'b1, 1'b0, 6'b001001};
        tbl[13] = '{1'b0, 6'd7, 6'd30, 6'd1,  1'b1, 1'b1, 1'b0, 6'b001001};
        tbl[14] = '{1'b1, 6'd7, 6'd30, 6'd3,  1'b1, 1'b0, 1'b0, 6'b001001};
        tbl[15] = '{1'b0, 6'd7, 6'd30, 6'd3,  1'b0, 1'b0, 1'b0, 6'b000000};
        tbl[16] = '{1'b1, 6'd7, 6'd31, 6'd0,  1'b1, 1'b0, 1'b0, 6'b000000};
        tbl[17] = '{1'b1, 6'd7, 6'd30, 6'd0,  1'b1, 1'b0, 1'b0, 6'b110000};
        tbl[18] = '{1'b1, 6'd7, 6'd30, 6'd1,  1'b1, 1'b1, 1'b0, 6'b001001};
        tbl[19] = '{1'b0, 6'd7, 6'd30, 6'd1,  1'b1, 1'b0, 1'b1, 6'b000000};

        // reset state
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("reset", outs(), 6'b000000);
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0);
        check("idle_after_reset", outs(), 6'b000000);

        // table-driven single-cycle vectors
        for (int i = 0; i < 20; i++) begin
            set_time(tbl[i].h, tbl[i].m, tbl[i].s);
            alarm_en = tbl[i].en;
            step(tbl[i].tick, tbl[i].snz, tbl[i].stp);
            check($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end
        alarm_en = 1'b1;

        // full ring timeout; alarm time edited mid-event must not matter
        fire_alarm();
        check("timeout_start", outs(), 6'b110000);
        sethour = 6'd8;
        setmin  = 6'd0;
        for (int k = 1; k <= 59; k++) begin
            quiet_tick();
            check($sformatf("timeout_tick%0d", k), outs(),
                  {1'b1, ((k % 2) == 0) ? 1'b1 : 1'b0, 1'b0, 3'd0});
        end
        quiet_tick();
        check("timeout_tick60", outs(), 6'b000000);
        sethour = 6'd7;
        setmin  = 6'd30;

        // three full snoozes, then the fourth request is ignored
        fire_alarm();
        for (int n = 1; n <= 3; n++) begin
            step(1'b0, 1'b1, 1'b0);
            check($sformatf("snooze%0d_enter", n), outs(), {3'b001, 3'(n)});
            for (int k = 1; k <= 299; k++) quiet_tick();
            check($sformatf("snooze%0d_tick299", n), outs(), {3'b001, 3'(n)});
            quiet_tick();
            check($sformatf("snooze%0d_rering", n), outs(), {3'b110, 3'(n)});
        end
        step(1'b0, 1'b1, 1'b0);
        check("snooze4_ignored", outs(), 6'b110011);
        quiet_tick();
        check("tick_after_ignored", outs(), 6'b100011);
        step(1'b0, 1'b0, 1'b1);
        check("stop_after_max", outs(), 6'b000000);

        // reset mid-ring, then a non-zero-second time must not ring
        fire_alarm();
        quiet_tick();
        check("pre_reset_ring", outs(), 6'b100000);
        rst = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        check("reset_mid_ring", outs(), 6'b000000);
        rst = 1'b0;
        set_time(6'd7, 6'd30, 6'd1);
        step(1'b1, 1'b0, 1'b0);
        check("sec1_no_ring", outs(), 6'b000000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alarm_ringer.md
# alarm_ringer

Downstream consumer of the alarm state controller's `sethour`/`setmin` registers and of the running clock counter's current time. Compares current time against the stored alarm time once per second, raises and holds the ring/buzzer outputs, and handles snooze (bounded count) and stop requests. Output drives the buzzer pin and the "alarm active" LED.

## Interface
Parameters:
- `SNOOZE_MIN`, 5, snooze length in minutes (1..30)
- `RING_TIMEOUT_S`, 60, seconds of ringing before auto-stop (1..255)
- `MAX_SNOOZE`, 3, maximum snoozes per alarm event (0..7)

Ports (one clock `clk`; reset `rst` is synchronous, active-high):
- `clk`  in  1  system clock
- `rst`  in  1  synchronous active-high reset
- `tick_1hz`  in  1  one-`clk`-cycle strobe, once per second
- `cur_hour`  in  6  current hour, 0..23
- `cur_min`  in  6  current minute, 0..59
- `cur_sec`  in  6  current second, 0..59
- `sethour`  in  6  alarm hour, 0..23
- `setmin`  in  6  alarm minute, 0..59
- `alarm_en`  in  1  alarm armed (level)
- `snooze`  in  1  snooze request, single-cycle pulse (debounced upstream)
- `stop`  in  1  stop request, single-cycle pulse
- `ring`  out  1  high while in RINGING
- `buzzer`  out  1  beep pattern, toggles each tick while RINGING
- `snoozing`  out  1  high while in SNOOZE
- `snooze_cnt`  out  3  snoozes used in current event

## Operation
- States: IDLE, RINGING, SNOOZE. Reset -> IDLE.
- Match = `alarm_en` & `tick_1hz` & `cur_hour==sethour` & `cur_min==setmin` & `cur_sec==0`. Fires exactly once per matching minute; no lockout state needed.
- IDLE: on match -> RINGING, load ring timer with `RING_TIMEOUT_S`, `snooze_cnt`<=0, `buzzer`<=1.
- RINGING: each tick decrements ring timer and toggles `buzzer`. Timer reaching 0 on a tick -> IDLE. `snooze` with `snooze_cnt<MAX_SNOOZE` -> SNOOZE, `snooze_cnt`+1, load snooze timer with `SNOOZE_MIN*60`. `snooze` with `snooze_cnt==MAX_SNOOZE` ignored.
- SNOOZE: each tick decrements snooze timer; reaching 0 -> RINGING, reload ring timer, `buzzer`<=1. `snooze` ignored.
- `stop` in RINGING or SNOOZE -> IDLE, `snooze_cnt`<=0.
- `alarm_en` low in any state -> IDLE next cycle (acts as stop).
- Priority per cycle: `rst` > `alarm_en` low > `stop` > `snooze` > timer expiry > tick decrement.
- Match while in RINGING/SNOOZE ignored (event already active).
- `sethour`/`setmin` changes during an active event do not affect it.
- Timers unsigned, width `$clog2(SNOOZE_MIN*60+1)` and 8 bits; never decrement below 0.

## Timing
- All outputs registered; reset values: `ring`=0, `buzzer`=0, `snoozing`=0, `snooze_cnt`=0, timers 0.
- Match on cycle N -> `ring`=1, `buzzer`=1 at N+1.
- `stop`/`snooze`/`alarm_en` low on cycle N -> outputs reflect new state at N+1.
- Ring length: exactly `RING_TIMEOUT_S` ticks after entry; snooze length exactly `SNOOZE_MIN*60` ticks.
- Pulses on `snooze`/`stop` coincident with `tick_1hz` are honoured; tick decrement is discarded on that cycle.
- `rst` mid-event: IDLE next cycle, all outputs at reset values.

## Structure
- Shared package `alarm_pkg`: state enum (IDLE/RINGING/SNOOZE), `TIME_W`=6, max-hour/max-minute constants, shared with the state controller and clock counter.
- One sub-module `tick_timer`: loadable down-counter, `load`/`value`/`tick` in, `zero` out; instantiated twice (ring, snooze).
- FSM and comparator in top.

## Test plan
- Alarm 07:30, time steps 07:29:59 -> 07:30:00 with tick -> `ring`=1 next cycle, `buzzer` toggles each tick, `ring`=0 after 60 ticks.
- Ringing, `snooze` pulse -> `snoozing`=1, `snooze_cnt`=1; after 300 ticks `ring`=1 again.
- Snooze 3 times, 4th `snooze` -> ignored, `ring` stays 1, `snooze_cnt`=3.
- `stop` and `snooze` same cycle while RINGING -> IDLE, `snooze_cnt`=0.
- `alarm_en`=0 at match time -> `ring` stays 0; `alarm_en` dropped during SNOOZE -> IDLE next cycle.
- `rst` asserted mid-RINGING -> all outputs 0 next cycle; match at 07:30:01 (sec≠0) -> no ring.
